// File: rtl/ascii8_mapper_pkg.sv
// Shared types and address constants for the ASCII-8 MegaROM mapper.
package ascii8_mapper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEM_REQ,
      ST_MEM_DATA,
      ST_RESP
   } state_t;

   localparam logic [15:0] WIN_LO = 16'h4000;
   localparam logic [15:0] WIN_HI = 16'hBFFF;
   localparam logic [15:0] REG_LO = 16'h6000;
   localparam logic [15:0] REG_HI = 16'h7FFF;

   localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

   // 4000h-5FFFh is window 0, so the window index is address[15:13] - 2
   function automatic logic [1:0] window_index(input logic [15:0] address);
      logic [2:0] idx;
      idx = address[15:13] - 3'd2;
      return idx[1:0];
   endfunction

endpackage

// File: rtl/ascii8_mapper_if.sv
// Cartridge-bus and memory-controller interfaces of the ASCII-8 mapper.
interface ascii8_bus_if;
   logic        sltsl;
   logic        bus_memory_req;
   logic        bus_ack;
   logic        bus_wrt;
   logic [15:0] bus_address;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        bus_rdata_en;

   modport master (
      output sltsl, bus_memory_req, bus_wrt, bus_address, bus_wdata,
      input  bus_ack, bus_rdata, bus_rdata_en
   );

   modport slave (
      input  sltsl, bus_memory_req, bus_wrt, bus_address, bus_wdata,
      output bus_ack, bus_rdata, bus_rdata_en
   );
endinterface

interface ascii8_mem_if #(
   parameter int BANK_BITS = 8
);
   logic                   mem_req;
   logic                   mem_ack;
   logic                   mem_wrt;
   logic [12+BANK_BITS:0]  mem_address;
   logic [7:0]             mem_wdata;
   logic [7:0]             mem_rdata;
   logic                   mem_rdata_en;
   logic                   mem_sram;

   modport master (
      output mem_req, mem_wrt, mem_address, mem_wdata, mem_sram,
      input  mem_ack, mem_rdata, mem_rdata_en
   );

   modport slave (
      input  mem_req, mem_wrt, mem_address, mem_wdata, mem_sram,
      output mem_ack, mem_rdata, mem_rdata_en
   );
endinterface

// File: rtl/ascii8_bank_regs.sv
// Four ASCII-8 bank registers plus the bus address decoder.
// ASCII8_SRAM_EN: bank bit BANK_BITS-1 selects the 8 KB SRAM instead of ROM.
module ascii8_bank_regs
   import ascii8_mapper_pkg::*;
#(
   parameter int BANK_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [15:0]          address,
   input  logic [7:0]           wdata,
   output logic [BANK_BITS-1:0] bank,
   output logic                 win_hit,
   output logic                 reg_hit,
   output logic                 sram,
   output logic                 sram_writable
);

   logic [3:0][BANK_BITS-1:0] banks;
   logic [3:0]                bank_we;
   logic [1:0]                win_idx;
   logic [1:0]                reg_idx;

   assign win_hit = (address >= WIN_LO) && (address <= WIN_HI);
   assign reg_hit = (address >= REG_LO) && (address <= REG_HI);
   assign win_idx = window_index(address);
   assign reg_idx = address[12:11];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bank
         logic [BANK_BITS-1:0] value_reg;

         assign bank_we[gi] = wr_en && (reg_idx == 2'(gi));

         always_ff @(posedge clk) begin
            if (reset) begin
               value_reg <= '0;
            end else if (bank_we[gi]) begin
               value_reg <= wdata[BANK_BITS-1:0];
            end
         end

         assign banks[gi] = value_reg;
      end
   endgenerate

   assign bank = banks[win_idx];

`ifdef ASCII8_SRAM_EN
   assign sram = win_hit && bank[BANK_BITS-1];
`else
   assign sram = 1'b0;
`endif

   // SRAM is only writable through the upper two windows (8000h-BFFFh)
   assign sram_writable = sram && win_idx[1];

endmodule

// File: rtl/ascii8_mapper.sv
// ASCII-8 MegaROM mapper: bus request FSM translating CPU accesses to linear memory requests.
// ASCII8_SRAM_EN (via ascii8_bank_regs) enables the SRAM mapping and SRAM writes.
module ascii8_mapper
   import ascii8_mapper_pkg::*;
#(
   parameter int BANK_BITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   ascii8_bus_if.slave bus,
   ascii8_mem_if.master mem
);

   localparam int ADDR_W = 13 + BANK_BITS;

   state_t              state_reg, state_next;
   logic                bus_ack_reg, bus_ack_next;
   logic [7:0]          bus_rdata_reg, bus_rdata_next;
   logic                bus_rdata_en_reg, bus_rdata_en_next;
   logic                mem_req_reg, mem_req_next;
   logic                mem_wrt_reg, mem_wrt_next;
   logic [ADDR_W-1:0]   mem_address_reg, mem_address_next;
   logic [7:0]          mem_wdata_reg, mem_wdata_next;
   logic                mem_sram_reg, mem_sram_next;

   logic [BANK_BITS-1:0] bank;
   logic                 win_hit;
   logic                 reg_hit;
   logic                 sram;
   logic                 sram_writable;
   logic                 bank_wr;
   logic                 accept;
   logic [ADDR_W-1:0]    rom_address;
   logic [ADDR_W-1:0]    sram_address;

   ascii8_bank_regs #(
      .BANK_BITS (BANK_BITS)
   ) u_bank_regs (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (bank_wr),
      .address       (bus.bus_address),
      .wdata         (bus.bus_wdata),
      .bank          (bank),
      .win_hit       (win_hit),
      .reg_hit       (reg_hit),
      .sram          (sram),
      .sram_writable (sram_writable)
   );

   // The bus still holds the request during the ack cycle, so it is masked there
   assign accept       = bus.sltsl && bus.bus_memory_req && !bus_ack_reg;
   assign rom_address  = {bank, bus.bus_address[12:0]};
   assign sram_address = {{BANK_BITS{1'b0}}, bus.bus_address[12:0]};

   always_comb begin
      state_next        = state_reg;
      bus_ack_next      = 1'b0;
      bus_rdata_next    = bus_rdata_reg;
      bus_rdata_en_next = 1'b0;
      mem_req_next      = mem_req_reg;
      mem_wrt_next      = mem_wrt_reg;
      mem_address_next  = mem_address_reg;
      mem_wdata_next    = mem_wdata_reg;
      mem_sram_next     = mem_sram_reg;
      bank_wr           = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               bus_ack_next = 1'b1;
               if (bus.bus_wrt) begin
                  if (reg_hit) begin
                     bank_wr = 1'b1;
                  end else if (sram_writable) begin
                     mem_req_next     = 1'b1;
                     mem_wrt_next     = 1'b1;
                     mem_address_next = sram_address;
                     mem_wdata_next   = bus.bus_wdata;
                     mem_sram_next    = 1'b1;
                     state_next       = ST_MEM_REQ;
                  end
               end else if (win_hit) begin
                  mem_req_next     = 1'b1;
                  mem_wrt_next     = 1'b0;
                  mem_address_next = sram ? sram_address : rom_address;
                  mem_sram_next    = sram;
                  state_next       = ST_MEM_REQ;
               end else begin
                  bus_rdata_next = UNMAPPED_DATA;
                  state_next     = ST_RESP;
               end
            end
         end

         ST_MEM_REQ: begin
            if (mem.mem_ack) begin
               mem_req_next = 1'b0;
               if (mem_wrt_reg) begin
                  state_next = ST_IDLE;
               end else if (mem.mem_rdata_en) begin
                  bus_rdata_next    = mem.mem_rdata;
                  bus_rdata_en_next = 1'b1;
                  state_next        = ST_RESP;
               end else begin
                  state_next = ST_MEM_DATA;
               end
            end
         end

         ST_MEM_DATA: begin
            if (mem.mem_rdata_en) begin
               bus_rdata_next    = mem.mem_rdata;
               bus_rdata_en_next = 1'b1;
               state_next        = ST_RESP;
            end
         end

         ST_RESP: begin
            // Memory reads enter with the pulse already raised; unmapped reads raise it here
            if (bus_rdata_en_reg) begin
               state_next = ST_IDLE;
            end else begin
               bus_rdata_en_next = 1'b1;
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         bus_ack_reg      <= 1'b0;
         bus_rdata_reg    <= UNMAPPED_DATA;
         bus_rdata_en_reg <= 1'b0;
         mem_req_reg      <= 1'b0;
         mem_wrt_reg      <= 1'b0;
         mem_address_reg  <= '0;
         mem_wdata_reg    <= '0;
         mem_sram_reg     <= 1'b0;
      end else begin
         state_reg        <= state_next;
         bus_ack_reg      <= bus_ack_next;
         bus_rdata_reg    <= bus_rdata_next;
         bus_rdata_en_reg <= bus_rdata_en_next;
         mem_req_reg      <= mem_req_next;
         mem_wrt_reg      <= mem_wrt_next;
         mem_address_reg  <= mem_address_next;
         mem_wdata_reg    <= mem_wdata_next;
         mem_sram_reg     <= mem_sram_next;
      end
   end

   assign bus.bus_ack      = bus_ack_reg;
   assign bus.bus_rdata    = bus_rdata_reg;
   assign bus.bus_rdata_en = bus_rdata_en_reg;
   assign mem.mem_req      = mem_req_reg;
   assign mem.mem_wrt      = mem_wrt_reg;
   assign mem.mem_address  = mem_address_reg;
   assign mem.mem_wdata    = mem_wdata_reg;
   assign mem.mem_sram     = mem_sram_reg;

endmodule

// File: tb/tb_ascii8_mapper.sv
// Scoreboard bench for ascii8_mapper: bus driver, memory responder model and read-data monitor.
module tb_ascii8_mapper;

   localparam int BANK_BITS = 8;

   typedef struct packed {
      logic [20:0] addr;
      logic        wrt;
      logic [7:0]  wdata;
      logic        sram;
   } mem_exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ascii8_bus_if bus_if ();
   ascii8_mem_if #(.BANK_BITS(BANK_BITS)) mem_if ();

   ascii8_mapper #(.BANK_BITS(BANK_BITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if),
      .mem   (mem_if)
   );

   int checks = 0;
   int errors = 0;

   mem_exp_t   mem_q[$];
   logic [7:0] data_q[$];
   int         en_hist[$];

   int ack_count = 0;
   int en_count = 0;
   int n_acc = 0;
   int last_ack_cyc = 0;
   int mem_rise_cyc = 0;
   int mem_en_cyc = 0;
   int ack_delay = 0;
   int data_delay = 1;
   bit combined = 1'b0;
   bit resp_en = 1'b1;
   bit resp_busy = 1'b0;
   int inject_req = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mem_fn(input logic [20:0] a);
      return 8'h5A ^ a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]};
   endfunction

   // Memory controller model: checks each request against the scoreboard and answers it
   initial begin
      mem_exp_t e;
      bit       known;
      int       inject_done;
      inject_done = 0;
      mem_if.mem_ack      = 1'b0;
      mem_if.mem_rdata_en = 1'b0;
      mem_if.mem_rdata    = 8'h00;
      forever begin
         @(negedge clk);
         if (inject_req != inject_done) begin
            inject_done         = inject_req;
            mem_if.mem_rdata_en = 1'b1;
            mem_if.mem_rdata    = 8'h33;
            @(negedge clk);
            mem_if.mem_rdata_en = 1'b0;
         end else if (resp_en && mem_if.mem_req === 1'b1) begin
            resp_busy    = 1'b1;
            mem_rise_cyc = cyc;
            known        = (mem_q.size() != 0);
            if (known) begin
               e = mem_q.pop_front();
               check("mem_address", 32'(mem_if.mem_address), 32'(e.addr));
               check("mem_wrt", 32'(mem_if.mem_wrt), 32'(e.wrt));
               check("mem_sram", 32'(mem_if.mem_sram), 32'(e.sram));
               if (e.wrt) check("mem_wdata", 32'(mem_if.mem_wdata), 32'(e.wdata));
            end else begin
               check("unexpected_mem_req", 32'(mem_if.mem_req), 0);
               e = '0;
            end
            for (int i = 0; i < ack_delay; i++) begin
               @(negedge clk);
               check("mem_req_held", 32'(mem_if.mem_req), 1);
               if (known) check("mem_address_stable", 32'(mem_if.mem_address), 32'(e.addr));
            end
            mem_if.mem_ack = 1'b1;
            if (!e.wrt && combined) begin
               mem_if.mem_rdata_en = 1'b1;
               mem_if.mem_rdata    = mem_fn(e.addr);
               mem_en_cyc          = cyc;
            end
            @(negedge clk);
            mem_if.mem_ack      = 1'b0;
            mem_if.mem_rdata_en = 1'b0;
            check("mem_req_drop", 32'(mem_if.mem_req), 0);
            if (!e.wrt && !combined) begin
               repeat (data_delay) @(negedge clk);
               mem_if.mem_rdata_en = 1'b1;
               mem_if.mem_rdata    = mem_fn(e.addr);
               mem_en_cyc          = cyc;
               @(negedge clk);
               mem_if.mem_rdata_en = 1'b0;
            end
            resp_busy = 1'b0;
         end
      end
   end

   // Bus-side monitor: counts ack pulses and compares every read completion
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (bus_if.bus_ack === 1'b1) ack_count++;
         if (bus_if.bus_rdata_en === 1'b1) begin
            en_count++;
            en_hist.push_back(cyc);
            if (data_q.size() == 0) begin
               check("unexpected_rdata_en", 32'(bus_if.bus_rdata_en), 0);
            end else begin
               exp = data_q.pop_front();
               check("bus_rdata", 32'(bus_if.bus_rdata), 32'(exp));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic wait_ack(output int c);
      int n;
      n = 0;
      while (bus_if.bus_ack !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("ack_seen", 32'(bus_if.bus_ack), 1);
      c = cyc;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((data_q.size() != 0 || mem_q.size() != 0 || resp_busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", 32'(data_q.size() + mem_q.size()), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic bus_access(input logic w, input logic [15:0] a, input logic [7:0] d);
      int c;
      bus_if.sltsl          = 1'b1;
      bus_if.bus_memory_req = 1'b1;
      bus_if.bus_wrt        = w;
      bus_if.bus_address    = a;
      bus_if.bus_wdata      = d;
      wait_ack(c);
      last_ack_cyc = c;
      @(negedge clk);
      check("ack_pulse", 32'(bus_if.bus_ack), 0);
      bus_if.bus_memory_req = 1'b0;
      bus_if.sltsl          = 1'b0;
      n_acc++;
   endtask

   task automatic rd(input logic [15:0] a, input logic [20:0] ma, input logic sram);
      mem_q.push_back('{addr: ma, wrt: 1'b0, wdata: 8'h00, sram: sram});
      data_q.push_back(mem_fn(ma));
      bus_access(1'b0, a, 8'h00);
      wait_idle();
      $display("read  %04h -> mem %06h", a, ma);
      check("mem_req_rise", 32'(mem_rise_cyc), 32'(last_ack_cyc));
      if (en_hist.size() > 0)
         check("rdata_en_latency", 32'(en_hist[en_hist.size()-1]), 32'(mem_en_cyc + 1));
   endtask

   task automatic rd_unmapped(input logic [15:0] a);
      data_q.push_back(8'hFF);
      bus_access(1'b0, a, 8'h00);
      wait_idle();
      $display("read  %04h unmapped", a);
      if (en_hist.size() > 0)
         check("unmapped_latency", 32'(en_hist[en_hist.size()-1]), 32'(last_ack_cyc + 1));
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      bus_access(1'b1, a, d);
      wait_idle();
      $display("write %04h = %02h (no memory access)", a, d);
   endtask

   task automatic wr_mem(input logic [15:0] a, input logic [7:0] d, input logic [20:0] ma);
      mem_q.push_back('{addr: ma, wrt: 1'b1, wdata: d, sram: 1'b1});
      bus_access(1'b1, a, d);
      wait_idle();
      $display("write %04h = %02h -> sram %06h", a, d, ma);
   endtask

   initial begin
      int base;
      int ca;
      int cb;
      bus_if.sltsl          = 1'b0;
      bus_if.bus_memory_req = 1'b0;
      bus_if.bus_wrt        = 1'b0;
      bus_if.bus_address    = 16'h0000;
      bus_if.bus_wdata      = 8'h00;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_bus_ack", 32'(bus_if.bus_ack), 0);
      check("rst_bus_rdata", 32'(bus_if.bus_rdata), 32'hFF);
      check("rst_bus_rdata_en", 32'(bus_if.bus_rdata_en), 0);
      check("rst_mem_req", 32'(mem_if.mem_req), 0);
      check("rst_mem_wrt", 32'(mem_if.mem_wrt), 0);
      check("rst_mem_address", 32'(mem_if.mem_address), 0);
      check("rst_mem_wdata", 32'(mem_if.mem_wdata), 0);
      check("rst_mem_sram", 32'(mem_if.mem_sram), 0);

      rd(16'h4000, 21'h000000, 1'b0);
      wr(16'h6800, 8'h03);
      wr(16'h7000, 8'h05);
      rd(16'h6123, 21'h006123, 1'b0);
      rd(16'h8010, 21'h00A010, 1'b0);
      wr(16'h7800, 8'h07);
      rd(16'hA001, 21'h00E001, 1'b0);
      wr(16'h6000, 8'h12);
      rd(16'h5FFF, 21'h025FFF, 1'b0);
      ack_delay = 2;
      data_delay = 3;
      rd(16'hBFFF, 21'h00FFFF, 1'b0);

      rd_unmapped(16'h0000);
      rd_unmapped(16'hC000);
      rd_unmapped(16'h3FFF);

      combined = 1'b1;
      ack_delay = 1;
      rd(16'h9FFF, 21'h00BFFF, 1'b0);
      combined = 1'b0;
      ack_delay = 0;
      data_delay = 1;

      wr(16'h4000, 8'hAA);
      wr(16'h8000, 8'h55);
      wr(16'h0000, 8'h01);

      base = ack_count;
      bus_if.sltsl          = 1'b0;
      bus_if.bus_memory_req = 1'b1;
      bus_if.bus_wrt        = 1'b0;
      bus_if.bus_address    = 16'h4000;
      repeat (5) @(negedge clk);
      check("sltsl_off_no_ack", 32'(ack_count), 32'(base));
      bus_if.bus_memory_req = 1'b0;
      $display("request without slot select ignored");

      // Second request is held on the bus while the first waits on a slow mem_ack
      ack_delay = 4;
      base = en_hist.size();
      mem_q.push_back('{addr: 21'h024001, wrt: 1'b0, wdata: 8'h00, sram: 1'b0});
      data_q.push_back(mem_fn(21'h024001));
      bus_if.sltsl          = 1'b1;
      bus_if.bus_memory_req = 1'b1;
      bus_if.bus_wrt        = 1'b0;
      bus_if.bus_address    = 16'h4001;
      wait_ack(ca);
      @(negedge clk);
      check("held_ack_pulse", 32'(bus_if.bus_ack), 0);
      bus_if.bus_address = 16'h8002;
      mem_q.push_back('{addr: 21'h00A002, wrt: 1'b0, wdata: 8'h00, sram: 1'b0});
      data_q.push_back(mem_fn(21'h00A002));
      wait_ack(cb);
      @(negedge clk);
      bus_if.bus_memory_req = 1'b0;
      bus_if.sltsl          = 1'b0;
      n_acc += 2;
      wait_idle();
      check("held_completions", 32'(en_hist.size() - base), 2);
      if (en_hist.size() >= base + 2)
         check("held_ack_after_rdata_en", 32'(cb > en_hist[base]), 1);
      $display("held request: first ack %0d, second ack %0d", ca, cb);
      ack_delay = 0;

`ifdef ASCII8_SRAM_EN
      wr(16'h7800, 8'h80);
      wr_mem(16'hA005, 8'h3C, 21'h000005);
      rd(16'hA005, 21'h000005, 1'b1);
      wr(16'h6000, 8'h80);
      wr(16'h4000, 8'h77);
      rd(16'h4123, 21'h000123, 1'b1);
`else
      wr(16'h7800, 8'h80);
      wr(16'hA005, 8'h3C);
      rd(16'hA005, 21'h100005, 1'b0);
`endif

      // Reset while mem_req is pending; the late mem_rdata_en must be dropped
      resp_en = 1'b0;
      bus_if.sltsl          = 1'b1;
      bus_if.bus_memory_req = 1'b1;
      bus_if.bus_wrt        = 1'b0;
      bus_if.bus_address    = 16'h4001;
      wait_ack(ca);
      n_acc++;
      @(negedge clk);
      check("pre_reset_mem_req", 32'(mem_if.mem_req), 1);
      bus_if.bus_memory_req = 1'b0;
      bus_if.sltsl          = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_drops_mem_req", 32'(mem_if.mem_req), 0);
      check("reset_bus_rdata", 32'(bus_if.bus_rdata), 32'hFF);
      base = en_count;
      inject_req++;
      repeat (6) @(negedge clk);
      check("reset_no_rdata_en", 32'(en_count), 32'(base));
      resp_en = 1'b1;
      $display("reset during memory request");

      rd(16'h6123, 21'h000123, 1'b0);

      check("ack_count", 32'(ack_count), 32'(n_acc));
      check("mem_queue_empty", 32'(mem_q.size()), 0);
      check("data_queue_empty", 32'(data_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
